// File: rtl/mult_pkg.sv
// mult_pkg -- shared types and defaults for the shift-add multiplier controller.
//   state_t     : controller FSM states (IDLE is the reset state)
//   DEF_WIDTH   : default operand width / number of shift-add steps
//   DEF_CNT_W   : default step counter width (>= clog2(WIDTH)+1)
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 6;

endpackage

// File: rtl/mult_step_counter.sv
// mult_step_counter -- shift-add step counter for the multiplier controller.
//   Clock, Reset : rising-edge clock, synchronous active-high reset
//   clear        : force count to 0 (used in LOAD)
//   enable       : increment count (used in CALC)
//   terminal     : high while count == WIDTH-1, i.e. on the last shift-add step
module mult_step_counter
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic Clock,
    input  logic Reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge Clock) begin
        if (Reset || clear)
            count <= '0;
        else if (enable)
            count <= count + 1'b1;
    end

    assign terminal = (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mult_controller.sv
// mult_controller -- FSM controller for a WIDTH x WIDTH unsigned shift-add
// multiplier. The datapath (A/B/Prod registers and adder) lives outside; this
// block only sequences it.
//   Clock, Reset   : rising-edge clock, synchronous active-high reset
//   Start          : begin one multiplication (sampled in IDLE only)
//   iB_LSB         : B[0] from the datapath, selects add in CALC
//   iB_Zero        : B == 0 from the datapath (early exit only)
//   a_sel, b_sel   : 0 = load operand, 1 = shift (when Shift_Enable)
//   prod_sel       : 0 = clear product, 1 = accumulate/hold
//   add_sel        : 1 = add shifted A into product this cycle
//   Shift_Enable   : shift A left / B right
//   Busy           : registered, high in LOAD and CALC
//   Done           : one-cycle pulse, product valid while high
// Optional feature: define MULT_EARLY_EXIT_EN to leave CALC as soon as B == 0.
module mult_controller
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Start,
    input  logic iB_LSB,
    input  logic iB_Zero,
    output logic a_sel,
    output logic b_sel,
    output logic add_sel,
    output logic prod_sel,
    output logic Shift_Enable,
    output logic Busy,
    output logic Done
);

    state_t state, next_state;
    logic   cnt_tc;
    logic   calc_exit;

    mult_step_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_step_cnt (
        .Clock    (Clock),
        .Reset    (Reset),
        .clear    (state == LOAD),
        .enable   (state == CALC),
        .terminal (cnt_tc)
    );

`ifdef MULT_EARLY_EXIT_EN
    // Once B has shifted down to zero no further adds can occur, so the
    // product is already final.
    assign calc_exit = cnt_tc | iB_Zero;
`else
    logic unused_b_zero;
    assign unused_b_zero = iB_Zero;
    assign calc_exit     = cnt_tc;
`endif

    // State register; Busy is decoded from next_state so it is a clean flop
    // aligned with the state it describes.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
            Busy  <= 1'b0;
        end else begin
            state <= next_state;
            Busy  <= (next_state == LOAD) || (next_state == CALC);
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (Start) next_state = LOAD;
            LOAD:    next_state = CALC;
            CALC:    if (calc_exit) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        a_sel        = 1'b0;
        b_sel        = 1'b0;
        prod_sel     = 1'b1;
        add_sel      = 1'b0;
        Shift_Enable = 1'b0;
        Done         = 1'b0;
        case (state)
            IDLE: ;
            LOAD: prod_sel = 1'b0;
            CALC: begin
                a_sel        = 1'b1;
                b_sel        = 1'b1;
                add_sel      = iB_LSB;
                Shift_Enable = 1'b1;
            end
            DONE: Done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mult_controller.sv
// tb_mult_controller -- directed, table-driven bench for mult_controller with a
// small behavioural shift-add datapath wrapped around it.
module tb_mult_controller;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic        a_sel, b_sel, add_sel, prod_sel, Shift_Enable, Busy, Done;
    logic [31:0] Data_A = '0, Data_B = '0;
    logic [63:0] ra = '0, prod = '0;
    logic [31:0] rb = '0;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    mult_controller #(.WIDTH(32), .CNT_W(6)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Start        (Start),
        .iB_LSB       (rb[0]),
        .iB_Zero      (rb == 32'd0),
        .a_sel        (a_sel),
        .b_sel        (b_sel),
        .add_sel      (add_sel),
        .prod_sel     (prod_sel),
        .Shift_Enable (Shift_Enable),
        .Busy         (Busy),
        .Done         (Done)
    );

    // Datapath model driven by the controller.
    always_ff @(posedge Clock) begin
        if (!a_sel) ra <= {32'd0, Data_A};
        else if (Shift_Enable) ra <= ra << 1;
        if (!b_sel) rb <= Data_B;
        else if (Shift_Enable) rb <= rb >> 1;
        if (!prod_sel) prod <= '0;
        else if (add_sel) prod <= prod + ra;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
        int          done_c;  // cycle (1 = cycle after Start is sampled) of Done
    } vec_t;

    // Launch one op; report Done cycle (-1 if none within bound), Busy cycles, product.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output int done_c, output int busy_c, output logic [63:0] p);
        done_c = -1;
        busy_c = 0;
        p      = 'x;
        @(negedge Clock);
        Data_A = a;
        Data_B = b;
        Start  = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        Start = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (c > 1) @(negedge Clock);
            if (Busy) busy_c++;
            if (Done) begin
                done_c = c;
                p      = prod;
                break;
            end
        end
    endtask

    vec_t vecs[6];

    initial begin
        int dc, bc, n_done;
        logic [63:0] p;

        // Two data-consuming CALC steps for B=2 etc; with early exit an extra
        // CALC cycle sees B==0 and leaves.
        vecs[0] = '{32'd3,          32'd5,          64'd15,                 34};
        vecs[1] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   64'hFFFFFFFE00000001,   34};
        vecs[2] = '{32'd7,          32'd2,          64'd14,                 34};
        vecs[3] = '{32'h12345678,   32'd0,          64'd0,                  34};
        vecs[4] = '{32'd1,          32'h80000000,   64'h80000000,           34};
        vecs[5] = '{32'hDEADBEEF,   32'd1,          64'hDEADBEEF,           34};
`ifdef MULT_EARLY_EXIT_EN
        vecs[0].done_c = 6;
        vecs[2].done_c = 5;
        vecs[3].done_c = 3;
        vecs[5].done_c = 4;
`endif

        // Reset with Start high: reset wins, controller stays idle.
        Start = 1'b1;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        chk("reset_outputs", {57'd0, a_sel, b_sel, prod_sel, add_sel, Shift_Enable, Busy, Done},
            {57'd0, 7'b0010000});
        Start = 1'b0;
        Reset = 1'b0;
        repeat (2) @(negedge Clock);
        chk("idle_after_reset", {62'd0, Busy, Done}, 64'd0);

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, dc, bc, p);
            chk($sformatf("v%0d_done_cycle", i), 64'(dc), 64'(vecs[i].done_c));
            chk($sformatf("v%0d_busy_cycles", i), 64'(bc), 64'(vecs[i].done_c - 1));
            chk($sformatf("v%0d_prod", i), p, vecs[i].p);
            @(negedge Clock);
            chk($sformatf("v%0d_done_pulse", i), {63'd0, Done}, 64'd0);
        end

        // Start re-pulsed mid-CALC with new operands: ignored.
        @(negedge Clock);
        Data_A = 32'd3; Data_B = 32'd5; Start = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        Start = 1'b0;
        n_done = 0; dc = -1;
        for (int c = 1; c <= 70; c++) begin
            if (c > 1) @(negedge Clock);
            if (c == 5) begin Data_A = 32'd9; Data_B = 32'd9; Start = 1'b1; end
            if (c == 7) Start = 1'b0;
            if (Done) begin
                n_done++;
                if (n_done == 1) begin dc = c; p = prod; end
            end
        end
        chk("repulse_done_count", 64'(n_done), 64'd1);
        chk("repulse_done_cycle", 64'(dc), 64'(vecs[0].done_c));
        chk("repulse_prod", p, 64'd15);

        // Reset at CALC step 10 (cycle 12): abort, no Done.
        @(negedge Clock);
        Data_A = 32'd3; Data_B = 32'hFFFF; Start = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        Start = 1'b0;
        repeat (11) @(negedge Clock);
        chk("pre_reset_busy", {63'd0, Busy}, 64'd1);
        Reset = 1'b1;
        @(negedge Clock);
        chk("abort_outputs", {60'd0, a_sel, b_sel, Busy, Done}, 64'd0);
        Reset = 1'b0;
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge Clock);
            if (Done || Busy) n_done++;
        end
        chk("abort_no_done", 64'(n_done), 64'd0);

        // Start held high: back-to-back ops with one IDLE cycle between.
        @(negedge Clock);
        Data_A = 32'd3; Data_B = 32'd5; Start = 1'b1;
        @(posedge Clock);
        n_done = 0; dc = -1; bc = -1;
        for (int c = 1; c <= 75; c++) begin
            @(negedge Clock);
            if (Done) begin
                n_done++;
                if (n_done == 1) dc = c;
                if (n_done == 2) bc = c;
                chk($sformatf("b2b_prod%0d", n_done), prod, 64'd15);
            end
            if (c == vecs[0].done_c + 1)
                chk("b2b_idle_gap", {63'd0, Busy}, 64'd0);
            if (c == vecs[0].done_c + 2)
                chk("b2b_reload", {63'd0, Busy}, 64'd1);
        end
        Start = 1'b0;
        chk("b2b_first_done", 64'(dc), 64'(vecs[0].done_c));
        chk("b2b_second_done", 64'(bc), 64'(2 * vecs[0].done_c + 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
